// File: rtl/trigger_capture_timer_pkg.sv
// Shared definitions for the trigger capture timer: FSM encoding and parameter defaults.
package trigger_capture_timer_pkg;

  localparam int unsigned COUNT_WIDTH_DEF = 32;
  localparam int unsigned TIMEOUT_DEF     = 16777215;
  localparam int unsigned MIN_PULSE_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/trigger_capture_timer_if.sv
// Control/status bundle between a capture controller (master) and the timer (slave).
interface trigger_capture_timer_if
  import trigger_capture_timer_pkg::*;
#(
  parameter int unsigned pCOUNT_WIDTH = COUNT_WIDTH_DEF
);

  logic                    trig_in;
  logic                    arm;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic                    timeout;
  logic [pCOUNT_WIDTH-1:0] cycle_count;
  logic                    trig_stretch;

  modport master (
    output trig_in, arm, abort,
    input  busy, done, timeout, cycle_count, trig_stretch
  );

  modport slave (
    input  trig_in, arm, abort,
    output busy, done, timeout, cycle_count, trig_stretch
  );

endinterface

// File: rtl/trigger_capture_timer_stretch.sv
// Registered trigger copy, held high at least pMIN_PULSE cycles from each rising edge.
module trig_pulse_stretch
  import trigger_capture_timer_pkg::*;
#(
  parameter int unsigned pMIN_PULSE = MIN_PULSE_DEF
) (
  input  logic ext_clock,
  input  logic reset_n,
  input  logic trig_in,
  output logic trig_stretch
);

  // The rising-edge cycle is the first of the minimum, so reload with one less.
  localparam logic [7:0] HOLD = 8'(pMIN_PULSE - 1);

  logic       trig_q;
  logic [7:0] rem_q;
  logic       str_q;

  always_ff @(posedge ext_clock) begin
    if (!reset_n) begin
      trig_q <= 1'b0;
      rem_q  <= '0;
      str_q  <= 1'b0;
    end else begin
      trig_q <= trig_in;
      if (trig_in && !trig_q) begin
        str_q <= 1'b1;
        rem_q <= HOLD;
      end else if (trig_in) begin
        str_q <= 1'b1;
        if (rem_q != '0) rem_q <= rem_q - 8'd1;
      end else if (rem_q != '0) begin
        str_q <= 1'b1;
        rem_q <= rem_q - 8'd1;
      end else begin
        str_q <= 1'b0;
      end
    end
  end

  assign trig_stretch = str_q;

endmodule

// File: rtl/trigger_capture_timer.sv
// Arms on request, waits for a clean trigger rising edge, counts trigger-high cycles, times out if none.
module trigger_capture_timer
  import trigger_capture_timer_pkg::*;
#(
  parameter int unsigned pCOUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int unsigned pTIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned pMIN_PULSE   = MIN_PULSE_DEF
) (
  input  logic                 ext_clock,
  input  logic                 reset_n,
  trigger_capture_timer_if.slave bus
);

  localparam int unsigned      TCNT_W    = cnt_bits(pTIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(pTIMEOUT - 1);

  state_t                  state_q, state_d;
  logic                    trig_q;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic [pCOUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    to_q, to_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    trig_rise, tcnt_hit, cnt_full;
  logic                    stretch;

  // trig_q tracks trig_in in every state, so a level already high at arm is never an edge.
  assign trig_rise = bus.trig_in && !trig_q;
  assign tcnt_hit  = (tcnt_q == TCNT_LAST);
  assign cnt_full  = &cnt_q;

  always_ff @(posedge ext_clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      tcnt_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= bus.trig_in;
      tcnt_q  <= tcnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (bus.arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_rise)     state_d = ST_CAPTURE;
          else if (tcnt_hit) state_d = ST_DONE;
        end
        ST_CAPTURE: if (!bus.trig_in) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of every registered output, so status lines change on the same edge as the state.
  always_comb begin
    cnt_d  = cnt_q;
    to_d   = to_q;
    tcnt_d = tcnt_q;
    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
    if (bus.abort) begin
      cnt_d  = '0;
      to_d   = 1'b0;
      tcnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            cnt_d  = '0;
            to_d   = 1'b0;
            tcnt_d = '0;
          end
        end
        ST_ARMED: begin
          tcnt_d = tcnt_q + 1'b1;
          if (trig_rise) begin
            cnt_d = pCOUNT_WIDTH'(1);
          end else if (tcnt_hit) begin
            to_d  = 1'b1;
            cnt_d = '0;
          end
        end
        ST_CAPTURE: begin
          if (bus.trig_in && !cnt_full) cnt_d = cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  trig_pulse_stretch #(
    .pMIN_PULSE(pMIN_PULSE)
  ) u_stretch (
    .ext_clock   (ext_clock),
    .reset_n     (reset_n),
    .trig_in     (bus.trig_in),
    .trig_stretch(stretch)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = to_q;
  assign bus.cycle_count  = cnt_q;
  assign bus.trig_stretch = stretch;

endmodule

// File: tb/tb_trigger_capture_timer.sv
// Directed vector bench: two timers (32-bit and 4-bit count, timeout 50) share one stimulus stream.
module tb_trigger_capture_timer;
  import trigger_capture_timer_pkg::*;

  logic ext_clock = 1'b0;
  always #5 ext_clock = ~ext_clock;

  logic reset_n, arm, abort, trig;

  trigger_capture_timer_if #(.pCOUNT_WIDTH(32)) bus_a ();
  trigger_capture_timer_if #(.pCOUNT_WIDTH(4))  bus_b ();

  assign bus_a.arm = arm;  assign bus_a.abort = abort;  assign bus_a.trig_in = trig;
  assign bus_b.arm = arm;  assign bus_b.abort = abort;  assign bus_b.trig_in = trig;

  trigger_capture_timer #(.pCOUNT_WIDTH(32), .pTIMEOUT(50), .pMIN_PULSE(8)) dut_a (
    .ext_clock(ext_clock), .reset_n(reset_n), .bus(bus_a));
  trigger_capture_timer #(.pCOUNT_WIDTH(4), .pTIMEOUT(50), .pMIN_PULSE(8)) dut_b (
    .ext_clock(ext_clock), .reset_n(reset_n), .bus(bus_b));

  typedef struct {
    string       name;
    int          cyc;
    logic        rst_n, arm, abort, trig;
    logic        busy, done, tmo, str;
    int unsigned cnt;
  } vec_t;

  vec_t vt[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input int cyc, input logic r, input logic a, input logic ab,
                     input logic t, input logic bz, input logic dn, input logic to, input int unsigned c,
                     input logic s);
    vec_t v;
    v.name = nm; v.cyc = cyc; v.rst_n = r; v.arm = a; v.abort = ab; v.trig = t;
    v.busy = bz; v.done = dn; v.tmo = to; v.cnt = c; v.str = s;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge ext_clock);
    @(negedge ext_clock);
  endtask

  // Drive pat[i-1] before the i-th edge; report first edge index with stretch high and total high count.
  task automatic run_pulse(input string nm, input logic [39:0] pat, input int exp_first, input int exp_len);
    int first;
    int len;
    first = -1;
    len = 0;
    for (int i = 1; i <= 40; i++) begin
      trig = pat[i-1];
      step();
      if (bus_a.trig_stretch === 1'b1) begin
        if (first < 0) first = i;
        len++;
      end
    end
    trig = 1'b0;
    repeat (12) step();
    chk({nm, ".first"}, 64'(first), 64'(exp_first));
    chk({nm, ".len"},   64'(len),   64'(exp_len));
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;

    //   name            cyc rst arm abt trg  busy done tmo cnt  str
    add("reset",          2, 0,  0,  0,  0,   0,   0,   0,  0,   0);
    add("idle",           3, 1,  0,  0,  0,   0,   0,   0,  0,   0);
    add("armed_low",      5, 1,  1,  0,  0,   1,   0,   0,  0,   0);
    add("cap_first",      1, 1,  0,  0,  1,   1,   0,   0,  1,   1);
    add("cap_100_armign",99, 1,  1,  0,  1,   1,   0,   0,  100, 1);
    add("done_100",       1, 1,  0,  0,  0,   0,   1,   0,  100, 0);
    add("done_hold",     10, 1,  0,  0,  0,   0,   1,   0,  100, 0);
    add("armed_pre_to",  50, 1,  1,  0,  0,   1,   0,   0,  0,   0);
    add("timeout",        1, 1,  0,  0,  0,   0,   1,   1,  0,   0);
    add("rearm_to_clr",  50, 1,  1,  0,  0,   1,   0,   0,  0,   0);
    add("edge_at_to",     1, 1,  0,  0,  1,   1,   0,   0,  1,   1);
    add("done_after_edge",2, 1,  0,  0,  0,   0,   1,   0,  1,   1);
    add("pre_high",       3, 1,  0,  0,  1,   0,   1,   0,  1,   1);
    add("arm_while_high",20, 1,  1,  0,  1,   1,   0,   0,  0,   1);
    add("low_gap",        3, 1,  0,  0,  0,   1,   0,   0,  0,   0);
    add("second_high",   10, 1,  0,  0,  1,   1,   0,   0,  10,  1);
    add("done_10",        1, 1,  0,  0,  0,   0,   1,   0,  10,  0);
    add("arm_c",          2, 1,  1,  0,  0,   1,   0,   0,  0,   0);
    add("cap_5",          5, 1,  0,  0,  1,   1,   0,   0,  5,   1);
    add("abort_and_arm",  1, 1,  1,  1,  1,   0,   0,   0,  0,   1);
    add("idle_after_abt", 3, 1,  0,  0,  1,   0,   0,   0,  0,   1);
    add("arm_d",          2, 1,  1,  0,  0,   1,   0,   0,  0,   0);
    add("cap_4",          4, 1,  0,  0,  1,   1,   0,   0,  4,   1);
    add("reset_mid_cap",  1, 0,  0,  0,  1,   0,   0,   0,  0,   0);
    add("post_reset",     3, 1,  0,  0,  1,   0,   0,   0,  0,   1);
    add("post_reset_low",10, 1,  0,  0,  0,   0,   0,   0,  0,   0);

    foreach (vt[i]) begin
      reset_n = vt[i].rst_n; arm = vt[i].arm; abort = vt[i].abort; trig = vt[i].trig;
      step();
      arm = 1'b0; abort = 1'b0;
      repeat (vt[i].cyc - 1) step();
      chk({vt[i].name, ".busy"},   64'(bus_a.busy),         64'(vt[i].busy));
      chk({vt[i].name, ".done"},   64'(bus_a.done),         64'(vt[i].done));
      chk({vt[i].name, ".timeout"},64'(bus_a.timeout),      64'(vt[i].tmo));
      chk({vt[i].name, ".count"},  64'(bus_a.cycle_count),  64'(vt[i].cnt));
      chk({vt[i].name, ".stretch"},64'(bus_a.trig_stretch), 64'(vt[i].str));
      chk({vt[i].name, ".busy_w4"},64'(bus_b.busy),         64'(vt[i].busy));
      chk({vt[i].name, ".count_w4"},64'(bus_b.cycle_count),
          64'((vt[i].cnt > 15) ? 15 : vt[i].cnt));
    end

    // Stretcher corner cases with the FSM left idle.
    run_pulse("pulse_1",       40'h00000_00001, 1, 8);
    run_pulse("pulse_20",      40'h00000_FFFFF, 1, 20);
    run_pulse("pulse_restart", 40'h00000_00011, 1, 12);
    run_pulse("pulse_9",       40'h00000_001FF, 1, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
